// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: data width, opcodes, NOP encoding and fetch FSM states.
package cpu_pkg;

  localparam int unsigned XLEN = 16;

  // Major opcodes, held in instr[3:0].
  localparam logic [3:0] OP_JAL  = 4'b0000;
  localparam logic [3:0] OP_JALR = 4'b0001;
  localparam logic [3:0] OP_BEQ  = 4'b0010;
  localparam logic [3:0] OP_BLE  = 4'b0011;
  localparam logic [3:0] OP_LB   = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SB   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1100;
  localparam logic [3:0] OP_SUBI = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1110;

  // addi r0,r0,0
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 16'h000C;

  // IDLE/HOLD: no read outstanding. WAIT/DROP: exactly one read outstanding;
  // in DROP its response is discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  // Sequential fetch address, 16-bit modulo.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(2);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight, drives the IF/ID
// register and parks one returned instruction in a skid buffer while decode is stalled.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 16'h0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus2
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_pc_plus2_q, if_pc_plus2_d;

  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;

  logic            accept;
  logic [XLEN-1:0] redirect_tgt;

  // A bubble in IF/ID never blocks, even with decode stalled.
  assign accept       = !if_valid_q || !id_stall;
  assign redirect_tgt = redirect_pc & 16'hFFFE;

  // Next-state, request and IF/ID / skid buffer updates; redirect outranks everything.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_d         = 1'b0;
    addr_d        = addr_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus2_d = if_pc_plus2_q;
    buf_valid_d   = buf_valid_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;

    if (redirect_valid) begin
      if_valid_d  = 1'b0;
      if_instr_d  = NOP_INSTR;
      buf_valid_d = 1'b0;
      pc_d        = redirect_tgt;
      unique case (state_q)
        WAIT: begin
          if (imem_rvalid) begin
            req_d   = 1'b1;
            addr_d  = redirect_tgt;
          end else begin
            state_d = DROP;
          end
        end
        DROP: begin
          // The stale response arriving with the redirect frees the port, so the new
          // target can go out now instead of leaving nothing in flight.
          if (imem_rvalid) begin
            req_d   = 1'b1;
            addr_d  = redirect_tgt;
            state_d = WAIT;
          end
        end
        default: begin
          req_d   = 1'b1;
          addr_d  = redirect_tgt;
          state_d = WAIT;
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid && accept) begin
            if_valid_d    = 1'b1;
            if_instr_d    = imem_rdata;
            if_pc_d       = pc_q;
            if_pc_plus2_d = pc_inc(pc_q);
            pc_d          = pc_inc(pc_q);
            req_d         = 1'b1;
            addr_d        = pc_inc(pc_q);
          end else if (imem_rvalid) begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_q;
            pc_d        = pc_inc(pc_q);
            state_d     = HOLD;
          end else if (accept) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            if_valid_d    = buf_valid_q;
            if_instr_d    = buf_valid_q ? buf_instr_q : NOP_INSTR;
            if_pc_d       = buf_pc_q;
            if_pc_plus2_d = pc_inc(buf_pc_q);
            buf_valid_d   = 1'b0;
            req_d         = 1'b1;
            addr_d        = pc_q;
            state_d       = WAIT;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, PC and registered imem request; a reset forgets any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q    <= 1'b0;
      if_instr_q    <= NOP_INSTR;
      if_pc_q       <= '0;
      if_pc_plus2_q <= '0;
    end else begin
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus2_q <= if_pc_plus2_d;
    end
  end

  // One-entry skid buffer for a response that arrives while decode is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus2 = if_pc_plus2_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by a randomized phase checked against an
// in-order fetch-stream scoreboard, with a latency-programmable instruction memory model.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  bit rand_lat = 1'b0;

  fetch_stage #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h000C)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus2   (if_pc_plus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: a few fixed words, a byte-swap hash elsewhere.
  function automatic logic [15:0] mem(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0002: return 16'h5678;
      16'h0004: return 16'hABCD;
      default:  return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endcase
  endfunction

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  // Memory responder: a request seen in cycle k is answered with a one-cycle rvalid in
  // cycle k+latency; responses are delivered even if the fetch stage has moved on.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem(pend[0].addr);
      void'(pend.pop_front());
    end
    if (imem_req === 1'b1)
      pend.push_back('{imem_addr, cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat)});
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [15:0] exp_pc;
  logic [15:0] tgt;
  bit          stall_r, redir_r;
  int          consumed;

  initial begin
    rst            = 1'b1;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    imem_rvalid    = 1'b0;
    imem_rdata     = 16'h0000;
    repeat (3) tick();
    chk("rst_req", 16'(imem_req), 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", 16'(if_valid), 16'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_pc2", if_pc_plus2, 16'h0000);
    rst = 1'b0;

    // Sequential fetch, latency 1: requests at cycles 1, 3, 5.
    tick(); // c1
    chk("c1_req", 16'(imem_req), 16'd1);
    chk("c1_addr", imem_addr, 16'h0000);
    tick(); // c2
    chk("c2_req", 16'(imem_req), 16'd0);
    tick(); // c3
    chk("c3_req", 16'(imem_req), 16'd1);
    chk("c3_addr", imem_addr, 16'h0002);
    chk("c3_valid", 16'(if_valid), 16'd1);
    chk("c3_instr", if_instr, 16'h1234);
    chk("c3_pc", if_pc, 16'h0000);
    chk("c3_pc2", if_pc_plus2, 16'h0002);
    tick(); // c4
    tick(); // c5
    chk("c5_addr", imem_addr, 16'h0004);
    chk("c5_instr", if_instr, 16'h5678);
    chk("c5_pc", if_pc, 16'h0002);
    id_stall = 1'b1;

    // Response for 0x0004 arrives while decode is stalled: it is parked, nothing issued.
    tick(); // c6
    tick(); // c7
    chk("stall_req", 16'(imem_req), 16'd0);
    chk("stall_instr", if_instr, 16'h5678);
    chk("stall_pc", if_pc, 16'h0002);
    chk("stall_valid", 16'(if_valid), 16'd1);
    tick(); // c8
    chk("stall_req2", 16'(imem_req), 16'd0);
    id_stall = 1'b0;
    tick(); // c9
    chk("unstall_instr", if_instr, 16'hABCD);
    chk("unstall_pc", if_pc, 16'h0004);
    chk("unstall_req", 16'(imem_req), 16'd1);
    chk("unstall_addr", imem_addr, 16'h0006);
    tick(); // c10
    lat = 3;

    // Redirect to 0x0041 while the latency-3 read of 0x0008 is outstanding.
    tick(); // c11
    chk("c11_addr", imem_addr, 16'h0008);
    chk("c11_instr", if_instr, mem(16'h0006));
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0041;
    tick(); // c12
    redirect_valid = 1'b0;
    chk("redir_valid", 16'(if_valid), 16'd0);
    chk("redir_instr", if_instr, NOP);
    chk("redir_req", 16'(imem_req), 16'd0);
    tick();
    tick(); // c14
    chk("drop_valid", 16'(if_valid), 16'd0);
    chk("drop_req", 16'(imem_req), 16'd0);
    tick(); // c15
    chk("drop_reissue_req", 16'(imem_req), 16'd1);
    chk("drop_reissue_addr", imem_addr, 16'h0040);
    chk("drop_reissue_valid", 16'(if_valid), 16'd0);
    repeat (3) tick(); // c18
    chk("tgt_wait_valid", 16'(if_valid), 16'd0);
    tick(); // c19
    chk("tgt_valid", 16'(if_valid), 16'd1);
    chk("tgt_instr", if_instr, mem(16'h0040));
    chk("tgt_pc", if_pc, 16'h0040);
    chk("tgt_next_addr", imem_addr, 16'h0042);
    id_stall = 1'b1;

    // Redirect coincides with rvalid while decode is stalled: the flush wins.
    repeat (3) tick(); // c22
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    tick(); // c23
    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    chk("flush_valid", 16'(if_valid), 16'd0);
    chk("flush_instr", if_instr, NOP);
    chk("flush_req", 16'(imem_req), 16'd1);
    chk("flush_addr", imem_addr, 16'h0100);
    tick(); // c24
    lat = 1;
    repeat (3) tick(); // c27
    chk("flush_tgt_instr", if_instr, mem(16'h0100));
    chk("flush_tgt_pc", if_pc, 16'h0100);

    // Wrap-around at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick(); // c28
    redirect_valid = 1'b0;
    tick(); // c29
    chk("wrap_req_addr", imem_addr, 16'hFFFE);
    tick(); // c30
    lat = 2;
    tick(); // c31
    chk("wrap_pc", if_pc, 16'hFFFE);
    chk("wrap_pc2", if_pc_plus2, 16'h0000);
    chk("wrap_instr", if_instr, mem(16'hFFFE));
    chk("wrap_next_addr", imem_addr, 16'h0000);

    // Reset with a read in flight; its rvalid lands the cycle after release and is ignored.
    tick(); // c32
    rst = 1'b1;
    tick(); // c33
    rst = 1'b0;
    chk("mid_rst_valid", 16'(if_valid), 16'd0);
    chk("mid_rst_req", 16'(imem_req), 16'd0);
    chk("mid_rst_pc", if_pc, 16'h0000);
    tick(); // c34
    chk("post_rst_req", 16'(imem_req), 16'd1);
    chk("post_rst_addr", imem_addr, 16'h0000);
    chk("post_rst_valid", 16'(if_valid), 16'd0);
    tick(); // c35
    chk("stale_ignored", 16'(if_valid), 16'd0);
    repeat (2) tick(); // c37
    chk("post_rst_instr", if_instr, 16'h1234);
    chk("post_rst_pc", if_pc, 16'h0000);
    chk("post_rst_pc2", if_pc_plus2, 16'h0002);
    exp_pc = 16'h0002; // the word at 0x0000 is taken by decode on the next edge
    tick(); // c38
    rand_lat = 1'b1;

    // Random stalls and redirects: decode must see the exact sequential stream from each
    // redirect target, with matching instruction and link value.
    consumed = 0;
    for (int i = 0; i < 800; i++) begin
      stall_r = ($urandom_range(0, 2) == 0);
      redir_r = ($urandom_range(0, 24) == 0);
      tgt     = 16'($urandom);
      id_stall       = stall_r;
      redirect_valid = redir_r;
      redirect_pc    = tgt;
      if (if_valid !== 1'b1) chk("rnd_bubble_nop", if_instr, NOP);
      if (redir_r) begin
        exp_pc = tgt & 16'hFFFE;
      end else if (if_valid === 1'b1 && !stall_r) begin
        chk("rnd_pc", if_pc, exp_pc);
        chk("rnd_instr", if_instr, mem(exp_pc));
        chk("rnd_pc2", if_pc_plus2, exp_pc + 16'd2);
        exp_pc = exp_pc + 16'd2;
        consumed++;
      end
      tick();
    end
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    chk("rnd_progress", 16'(consumed >= 60), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
